// File: rtl/mux_21_arbiter.sv
// mux_21_arbiter
// Two-requester burst arbiter in front of a registered 2:1 datapath mux.
// A requester owns the mux for at most BURST_MAX accepted beats. Ownership
// ends early on the first granted cycle in which the owner's valid is low.
// Ties are broken round-robin against the last released owner.
//
// Optional build macro: MUX_ARB_FIXED_PRIO_EN
//   When defined, in0 always wins arbitration when it requests. last_grant
//   is still tracked but not consulted. BURST_MAX still bounds each burst.
//
// Ports
//   clk, rst             rising-edge clock, synchronous active-high reset
//   in0_valid/data/ready requester 0 valid/ready beat interface
//   in1_valid/data/ready requester 1 valid/ready beat interface
//   out_valid/data/ready registered output stage, downstream handshake
//   sel                  registered mux select (0 = in0, 1 = in1)
//   busy                 high while either requester holds the grant

// Per-requester handshake slice. A requester is ready only while it owns
// the grant and the output register can take a beat this cycle.
module mux_21_arbiter_port (
    input  logic granted,
    input  logic slot_free,
    input  logic valid,
    output logic ready,
    output logic accept
);
    assign ready  = granted && slot_free;
    assign accept = valid && ready;
endmodule

module mux_21_arbiter #(
    parameter int WIDTH     = 8,
    parameter int BURST_MAX = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in0_valid,
    input  logic [WIDTH-1:0] in0_data,
    output logic             in0_ready,
    input  logic             in1_valid,
    input  logic [WIDTH-1:0] in1_data,
    output logic             in1_ready,
    output logic             out_valid,
    output logic [WIDTH-1:0] out_data,
    input  logic             out_ready,
    output logic             sel,
    output logic             busy
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } state_t;

    state_t     state_q, state_d;
    logic       last_grant;
    logic [3:0] beat_cnt;

    // Requesters gathered into packed vectors so both slices share one body.
    logic [1:0]            req_vld;
    logic [1:0][WIDTH-1:0] req_data;
    logic [1:0]            req_gnt;
    logic [1:0]            req_rdy;
    logic [1:0]            req_acc;

    assign req_vld  = {in1_valid, in0_valid};
    assign req_data = {in1_data, in0_data};
    assign req_gnt  = {state_q == GNT1, state_q == GNT0};

    // Output register can take a beat if empty or being drained this cycle.
    logic slot_free;
    assign slot_free = !out_valid || out_ready;

    for (genvar n = 0; n < 2; n++) begin : g_port
        mux_21_arbiter_port u_port (
            .granted   (req_gnt[n]),
            .slot_free (slot_free),
            .valid     (req_vld[n]),
            .ready     (req_rdy[n]),
            .accept    (req_acc[n])
        );
    end

    assign in0_ready = req_rdy[0];
    assign in1_ready = req_rdy[1];
    assign busy      = (state_q != IDLE);

    // Index of the current owner; only meaningful in a grant state.
    logic owner;
    assign owner = (state_q == GNT1);

    logic       acc_any;
    logic [3:0] cnt_inc;
    logic       burst_end;
    logic       owner_vld;
    logic       release_gnt;

    assign acc_any   = |req_acc;
    assign cnt_inc   = beat_cnt + 4'd1;
    assign burst_end = acc_any && (cnt_inc == 4'(BURST_MAX));
    assign owner_vld = req_vld[owner];

    // Next-state: arbitration in IDLE, release out of the grant states.
    always_comb begin
        state_d     = state_q;
        release_gnt = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (in0_valid && in1_valid) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
                    state_d = GNT0;
`else
                    // last_grant == 1 means in1 had the bus last: in0 wins.
                    state_d = last_grant ? GNT0 : GNT1;
`endif
                end else if (in0_valid) begin
                    state_d = GNT0;
                end else if (in1_valid) begin
                    state_d = GNT1;
                end
            end
            GNT0, GNT1: begin
                // An idle owner never accepts, so the two causes are exclusive.
                if (burst_end || !owner_vld) begin
                    state_d     = IDLE;
                    release_gnt = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            last_grant <= 1'b1;
            beat_cnt   <= 4'd0;
            sel        <= 1'b0;
            out_valid  <= 1'b0;
            out_data   <= '0;
        end else begin
            state_q <= state_d;

            // Select moves only on grant entry and holds through IDLE.
            if (state_q == IDLE && state_d != IDLE)
                sel <= (state_d == GNT1);

            if (release_gnt) begin
                last_grant <= owner;
                beat_cnt   <= 4'd0;
            end else if (acc_any) begin
                beat_cnt <= cnt_inc;
            end

            // An accept refills the slot even if it is drained this cycle.
            if (acc_any) begin
                out_data  <= req_data[owner];
                out_valid <= 1'b1;
            end else if (out_valid && out_ready) begin
                out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_mux_21_arbiter.sv
module tb_mux_21_arbiter;

    localparam int W  = 8;
    localparam int BM = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic         in0_valid, in1_valid, out_ready;
    logic [W-1:0] in0_data, in1_data;
    logic         in0_ready, in1_ready, out_valid, sel, busy;
    logic [W-1:0] out_data;

    int tests = 0;
    int fails = 0;

    always #5 clk = ~clk;

    mux_21_arbiter #(.WIDTH(W), .BURST_MAX(BM)) dut (
        .clk       (clk),
        .rst       (rst),
        .in0_valid (in0_valid),
        .in0_data  (in0_data),
        .in0_ready (in0_ready),
        .in1_valid (in1_valid),
        .in1_data  (in1_data),
        .in1_ready (in1_ready),
        .out_valid (out_valid),
        .out_data  (out_data),
        .out_ready (out_ready),
        .sel       (sel),
        .busy      (busy)
    );

    task automatic chk(input string nm, input int act, input int exp);
        tests++;
        if (act != exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic drive(input logic v0, input logic [W-1:0] d0,
                         input logic v1, input logic [W-1:0] d1, input logic ordy);
        in0_valid = v0; in0_data = d0;
        in1_valid = v1; in1_data = d1;
        out_ready = ordy;
    endtask

    // Advance one clock; inputs are changed 1 time unit after the edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        repeat (2) tick();
        rst = 1'b0;
    endtask

    // ---------------- behavioural reference model ----------------
    int           m_owner;   // -1 = nobody owns the mux
    int           m_cnt;
    int           m_last;
    logic         m_ov, m_sel;
    logic [W-1:0] m_od;

    task automatic m_reset();
        m_owner = -1; m_cnt = 0; m_last = 1;
        m_ov = 1'b0; m_sel = 1'b0; m_od = '0;
    endtask

    task automatic m_check();
        int r0, r1;
        r0 = (m_owner == 0 && (!m_ov || out_ready)) ? 1 : 0;
        r1 = (m_owner == 1 && (!m_ov || out_ready)) ? 1 : 0;
        chk("rnd_out_valid", int'(out_valid), int'(m_ov));
        if (m_ov) chk("rnd_out_data", int'(out_data), int'(m_od));
        chk("rnd_sel", int'(sel), int'(m_sel));
        chk("rnd_busy", int'(busy), (m_owner >= 0) ? 1 : 0);
        chk("rnd_in0_ready", int'(in0_ready), r0);
        chk("rnd_in1_ready", int'(in1_ready), r1);
    endtask

    // Apply one clock edge of the rules to the model state.
    task automatic m_step();
        logic         vn;
        logic [W-1:0] dn;
        if (rst) begin
            m_reset();
            return;
        end
        if (m_owner < 0) begin
            if (in0_valid && in1_valid) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
                m_owner = 0;
`else
                m_owner = 1 - m_last;
`endif
            end else if (in0_valid) m_owner = 0;
            else if (in1_valid) m_owner = 1;
            if (m_owner >= 0) m_sel = (m_owner == 1);
            if (m_ov && out_ready) m_ov = 1'b0;
        end else begin
            vn = (m_owner == 1) ? in1_valid : in0_valid;
            dn = (m_owner == 1) ? in1_data : in0_data;
            if (vn && (!m_ov || out_ready)) begin
                m_od = dn;
                m_ov = 1'b1;
                m_cnt++;
                if (m_cnt == BM) begin
                    m_last = m_owner; m_owner = -1; m_cnt = 0;
                end
            end else begin
                if (m_ov && out_ready) m_ov = 1'b0;
                if (!vn) begin
                    m_last = m_owner; m_owner = -1; m_cnt = 0;
                end
            end
        end
    endtask

    // ---------------- table vectors: single in0 burst ----------------
    typedef struct {
        logic v0; logic [W-1:0] d0; logic v1; logic [W-1:0] d1; logic ordy;
        logic ov; logic [W-1:0] od; logic sl; logic bz; logic r0; logic r1;
    } vec_t;

    vec_t tbl[9];

    initial begin
        logic [W-1:0] q_data[$];
        logic         q_sel[$];
        int           i0, i1, a0, a1, seen_r1, k, exp_req, exp_idx;
        logic [W-1:0] held;

        //          v0    d0     v1    d1     ordy | ov    od     sel   busy  r0    r1
        tbl[0] = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[1] = '{1'b1, 8'h11, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[2] = '{1'b1, 8'h22, 1'b0, 8'h00, 1'b1, 1'b1, 8'h11, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[3] = '{1'b1, 8'h33, 1'b0, 8'h00, 1'b1, 1'b1, 8'h22, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[4] = '{1'b1, 8'h44, 1'b0, 8'h00, 1'b1, 1'b1, 8'h33, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[5] = '{1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 1'b1, 8'h44, 1'b0, 1'b0, 1'b0, 1'b0};
        tbl[6] = '{1'b1, 8'h55, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[7] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b1, 8'h55, 1'b0, 1'b1, 1'b1, 1'b0};
        tbl[8] = '{1'b0, 8'h00, 1'b0, 8'h00, 1'b1, 1'b0, 8'h00, 1'b0, 1'b0, 1'b0, 1'b0};

        // ---- reset with both requesters asserting ----
        rst = 1'b1;
        drive(1'b1, 8'hA0, 1'b1, 8'hB0, 1'b1);
        tick();
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_out_data", int'(out_data), 0);
        chk("rst_sel", int'(sel), 0);
        chk("rst_busy", int'(busy), 0);
        chk("rst_in0_ready", int'(in0_ready), 0);
        chk("rst_in1_ready", int'(in1_ready), 0);
        tick();
        rst = 1'b0;
        #1;
        chk("post_rst_idle", int'(busy), 0);
        tick();
        chk("first_grant_busy", int'(busy), 1);
        chk("first_grant_sel", int'(sel), 0);
        chk("first_grant_r0", int'(in0_ready), 1);
        chk("first_grant_r1", int'(in1_ready), 0);

        // ---- single burst from table ----
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        do_reset();
        for (int i = 0; i < 9; i++) begin
            drive(tbl[i].v0, tbl[i].d0, tbl[i].v1, tbl[i].d1, tbl[i].ordy);
            #1;
            chk($sformatf("tbl%0d_out_valid", i), int'(out_valid), int'(tbl[i].ov));
            if (tbl[i].ov) chk($sformatf("tbl%0d_out_data", i), int'(out_data), int'(tbl[i].od));
            chk($sformatf("tbl%0d_sel", i), int'(sel), int'(tbl[i].sl));
            chk($sformatf("tbl%0d_busy", i), int'(busy), int'(tbl[i].bz));
            chk($sformatf("tbl%0d_in0_ready", i), int'(in0_ready), int'(tbl[i].r0));
            chk($sformatf("tbl%0d_in1_ready", i), int'(in1_ready), int'(tbl[i].r1));
            tick();
        end

        // ---- tie: both requesters valid continuously ----
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        do_reset();
        i0 = 0; i1 = 0; seen_r1 = 0;
        for (int c = 0; c < 60 && q_data.size() < 12; c++) begin
            drive(1'b1, 8'(8'hA0 + i0), 1'b1, 8'(8'hB0 + i1), 1'b1);
            #1;
            a0 = int'(in0_ready);
            a1 = int'(in1_ready);
            if (in1_ready) seen_r1 = 1;
            if (out_valid) begin
                q_data.push_back(out_data);
                q_sel.push_back(sel);
            end
            tick();
            i0 += a0;
            i1 += a1;
        end
        chk("tie_beat_count", q_data.size(), 12);
        for (k = 0; k < 12 && k < q_data.size(); k++) begin
`ifdef MUX_ARB_FIXED_PRIO_EN
            exp_req = 0;
            exp_idx = k;
`else
            exp_req = (k / 4) % 2;
            exp_idx = (k / 8) * 4 + (k % 4);
`endif
            chk($sformatf("tie_data%0d", k), int'(q_data[k]),
                (exp_req == 1 ? 'hB0 : 'hA0) + exp_idx);
            chk($sformatf("tie_sel%0d", k), int'(q_sel[k]), exp_req);
        end
`ifdef MUX_ARB_FIXED_PRIO_EN
        chk("tie_in1_ready_seen", seen_r1, 0);
`else
        chk("tie_in1_ready_seen", seen_r1, 1);
`endif

        // ---- early release of in1 while in0 waits ----
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        do_reset();
        drive(1'b0, 8'h00, 1'b1, 8'h01, 1'b1);
        tick();
        drive(1'b1, 8'hC0, 1'b1, 8'h01, 1'b1);
        #1;
        chk("early_gnt1_sel", int'(sel), 1);
        chk("early_gnt1_r1", int'(in1_ready), 1);
        chk("early_gnt1_r0", int'(in0_ready), 0);
        tick();
        drive(1'b1, 8'hC0, 1'b1, 8'h02, 1'b1);
        tick();
        drive(1'b1, 8'hC0, 1'b0, 8'h00, 1'b1);
        #1;
        chk("early_drop_busy", int'(busy), 1);
        chk("early_drop_data", int'(out_data), 'h02);
        tick();
        #1;
        chk("early_idle_busy", int'(busy), 0);
        chk("early_idle_r0", int'(in0_ready), 0);
        tick();
        #1;
        chk("early_gnt0_busy", int'(busy), 1);
        chk("early_gnt0_sel", int'(sel), 0);
        chk("early_gnt0_r0", int'(in0_ready), 1);

        // ---- backpressure mid-burst ----
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        do_reset();
        drive(1'b1, 8'h10, 1'b0, 8'h00, 1'b1);
        tick();
        tick();                                  // 0x10 accepted
        drive(1'b1, 8'h11, 1'b0, 8'h00, 1'b0);
        held = 8'h10;
        for (int c = 0; c < 3; c++) begin
            #1;
            chk($sformatf("bp%0d_in0_ready", c), int'(in0_ready), 0);
            chk($sformatf("bp%0d_out_data", c), int'(out_data), int'(held));
            chk($sformatf("bp%0d_out_valid", c), int'(out_valid), 1);
            tick();
        end
        drive(1'b1, 8'h11, 1'b0, 8'h00, 1'b1);
        #1;
        chk("bp_resume_r0", int'(in0_ready), 1);
        chk("bp_resume_data", int'(out_data), 'h10);
        tick();
        drive(1'b1, 8'h12, 1'b0, 8'h00, 1'b1);
        #1;
        chk("bp_next_data", int'(out_data), 'h11);
        tick();
        #1;
        chk("bp_last_data", int'(out_data), 'h12);

        // ---- randomized run against the reference model ----
        drive(1'b0, 8'h00, 1'b0, 8'h00, 1'b1);
        do_reset();
        m_reset();
        for (int c = 0; c < 3000; c++) begin
            rst = ($urandom_range(0, 199) == 0);
            drive($urandom_range(0, 3) != 0, 8'($urandom),
                  $urandom_range(0, 3) != 0, 8'($urandom),
                  $urandom_range(0, 3) != 0);
            #1;
            m_check();
            m_step();
            tick();
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/mux_21_arbiter.md
# mux_21_arbiter

Two-requester burst arbiter that shares one registered 2:1 datapath mux, and the ALU operand bus behind it, between two sources. It decides which source owns the mux, drives the select, and moves data beats through a valid/ready handshake into a registered output stage. Arbitration is round-robin, and ownership is released after a bounded burst. It sits between the two operand sources and the ALU input register.

## Interface
Parameters:
- WIDTH, 8, data width of each input and of the output bus
- BURST_MAX, 4, maximum beats per grant (legal range 1..15)

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset; one clock; all state is sampled on clk
- in0_valid  input  1  requester 0 has a beat
- in0_data  input  WIDTH  requester 0 beat data
- in0_ready  output  1  requester 0 beat accepted this cycle when valid is also high
- in1_valid / in1_data / in1_ready  same as requester 0, for requester 1
- out_valid  output  1  out_data holds an unconsumed beat
- out_data  output  WIDTH  registered mux output
- out_ready  input  1  downstream consumes the beat when out_valid is also high
- sel  output  1  current mux select (0 = in0, 1 = in1); registered
- busy  output  1  high in either grant state

## Operation
- FSM states: IDLE, GNT0, GNT1. Reset state is IDLE.
- IDLE transitions:
  - If only inN_valid is high, go to GNTN.
  - If both are high, grant the requester that is not last_grant.
  - If neither is high, stay in IDLE.
- last_grant resets to 1, so in0 wins the first tie.
- In IDLE, in0_ready = in1_ready = 0. No beat is ever accepted in IDLE.
- inN_ready = (state == GNTN) && (!out_valid || out_ready). The other requester's ready is 0.
- Beat accept: inN_valid && inN_ready. On accept:
  - out_data <= inN_data.
  - out_valid <= 1.
  - beat_cnt increments.
- Output drain: if out_valid && out_ready and there is no accept in that cycle, out_valid <= 0.
- Grant release (go to IDLE, set last_grant <= N, clear beat_cnt) happens on either of:
  - an accept that makes beat_cnt reach BURST_MAX;
  - a cycle in GNTN with inN_valid == 0.
- sel is updated on entry to GNTN and holds its value through IDLE. out_data is not disturbed by a select change.
- beat_cnt is 4 bits wide; it never wraps because it is cleared at BURST_MAX.
- The other requester's valid during a grant has no effect until the grant is released.
- Reset mid-burst: the FSM returns to IDLE and the in-flight beat in the output register is dropped.
- Reset values: out_valid=0, out_data=0, sel=0, busy=0, in0_ready=0, in1_ready=0, last_grant=1, beat_cnt=0.

## Timing
- Arbitration latency is 1 cycle: a request seen in IDLE at edge k becomes a grant state after edge k. The earliest accept is in cycle k+1, and out_valid rises after edge k+1.
- Data latency is 1 cycle from accept to out_valid/out_data.
- Throughput: 1 beat/cycle within a burst while out_ready=1. There is a 1-cycle IDLE bubble between bursts.
- Backpressure: when out_valid=1 and out_ready=0, inN_ready=0 in the same cycle (combinational from registered out_valid and input out_ready). The held beat is not overwritten.
- Release and re-grant: release takes effect at the edge after the terminating condition. IDLE then needs one more cycle before the next grant.

## Configuration
- MUX_ARB_FIXED_PRIO_EN
  - Defined: IDLE always grants in0 when in0_valid is high, regardless of last_grant. last_grant is still maintained but unused. BURST_MAX still bounds in0's hold time.
  - Undefined (default): round-robin tie-break as described above.

## Test plan
- Reset: assert rst for 2 cycles with both valids high -> every output equals its reset value, and the first grant after rst drops is GNT0 (sel=0).
- Single burst: WIDTH=8, BURST_MAX=4, in0 presents 0x11,0x22,0x33,0x44,0x55 back-to-back with out_ready=1 -> out_data shows 0x11..0x44 on consecutive cycles, then 1 IDLE bubble. 0x55 only follows after a new grant.
- Round-robin tie: both valid continuously, in0 data 0xA0+i, in1 data 0xB0+i -> output bursts alternate 4×in0, 4×in1, 4×in0, and sel toggles at each grant.
- Early release: in1 drops valid after 2 beats (0x01,0x02) while in0 is waiting -> GNT1 exits the next cycle, and the grant passes to in0 after 1 IDLE cycle.
- Backpressure: out_ready held low 3 cycles mid-burst -> in0_ready=0 for those cycles, out_data is held stable, and no beat is lost or duplicated.
- Macro: with MUX_ARB_FIXED_PRIO_EN defined and both valid continuously -> only in0 is granted, as repeated 4-beat bursts separated by single IDLE cycles, and in1 never receives in1_ready=1.
